// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs register/immediate fields into a 32-bit word,
// flags illegal requests, and delivers results through a small in-order queue.
package riscv_pkg;
    localparam int RV_XLEN = 32;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'h03,
        OP_IMM    = 7'h13,
        OP_AUIPC  = 7'h17,
        OP_STORE  = 7'h23,
        OP_REG    = 7'h33,
        OP_LUI    = 7'h37,
        OP_BRANCH = 7'h63,
        OP_JALR   = 7'h67,
        OP_JAL    = 7'h6F,
        OP_SYSTEM = 7'h73
    } opcode_t;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    function automatic logic [RV_XLEN-1:0] i_imm(input logic [31:0] instr);
        return {{(RV_XLEN-12){instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [RV_XLEN-1:0] s_imm(input logic [31:0] instr);
        return {{(RV_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [RV_XLEN-1:0] b_imm(input logic [31:0] instr);
        return {{(RV_XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [RV_XLEN-1:0] u_imm(input logic [31:0] instr);
        return {{(RV_XLEN-32){instr[31]}}, instr[31:12], 12'h000};
    endfunction

    function automatic logic [RV_XLEN-1:0] j_imm(input logic [31:0] instr);
        return {{(RV_XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction
endpackage

module instr_encoder #(
    parameter int RV_XLEN = riscv_pkg::RV_XLEN,
    parameter int DEPTH   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [2:0]                   fmt_i,
    input  logic [6:0]                   opcode_i,
    input  logic [4:0]                   rd_i,
    input  logic [4:0]                   rs1_i,
    input  logic [4:0]                   rs2_i,
    input  logic [2:0]                   funct3_i,
    input  logic [6:0]                   funct7_i,
    input  logic [RV_XLEN-1:0]           imm_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [31:0]                  instr_o,
    output logic                         err_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    import riscv_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // True when every bit from msb upward matches, i.e. imm fits as a signed (msb+1)-bit value.
    function automatic logic sext_ok(input logic [RV_XLEN-1:0] v, input int unsigned msb);
        logic [RV_XLEN-1:0] s;
        s = RV_XLEN'($signed(v) >>> msb);
        return (s == '0) || (s == '1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [31:0]      enc_word;
    logic             enc_err;
    logic [31:0]      entry_instr;

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (fmt_i)
            FMT_R: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                enc_err  = !sext_ok(imm_i, 11);
            end
            FMT_S: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                enc_err  = !sext_ok(imm_i, 11);
            end
            FMT_B: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                enc_err  = !sext_ok(imm_i, 12) || imm_i[0];
            end
            FMT_U: begin
                enc_word = {imm_i[31:12], rd_i, opcode_i};
                enc_err  = (imm_i[11:0] != 12'h000) || !sext_ok(imm_i, 31);
            end
            FMT_J: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                enc_err  = !sext_ok(imm_i, 20) || imm_i[0];
            end
            default: enc_err = 1'b1;
        endcase
        if (opcode_i[1:0] != 2'b11) begin
            enc_err = 1'b1;
        end
    end

    assign entry_instr = enc_err ? 32'h0000_0000 : enc_word;

    logic [31:0]      mem_instr [DEPTH];
    logic             mem_err   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign req_ready_o = (count < CNT_W'(DEPTH));
    assign rsp_valid_o = (count != '0);
    assign push        = req_valid_i && req_ready_o && !flush_i;
    assign pop         = rsp_valid_o && rsp_ready_i && !flush_i;

    // NOTE: queue storage is left unreset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_instr[wr_ptr] <= entry_instr;
            mem_err[wr_ptr]   <= enc_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign instr_o = rsp_valid_o ? mem_instr[rd_ptr] : 32'h0000_0000;
    assign err_o   = rsp_valid_o ? mem_err[rd_ptr]   : 1'b0;
    assign count_o = count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based reference model compared every
// cycle, plus directed vectors with hand-computed encodings.
module tb_instr_encoder;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] instr;
    logic        err;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b1;

    instr_encoder #(.RV_XLEN(32), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .fmt_i       (fmt),
        .opcode_i    (opcode),
        .rd_i        (rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .imm_i       (imm),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .instr_o     (instr),
        .err_o       (err),
        .count_o     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: legality by numeric range, encoding by field placement; {err, word}.
    function automatic logic [32:0] model_encode(
        input logic [2:0] f, input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        int          s;
        bit          bad;
        logic [31:0] w;
        s   = int'(im);
        bad = (op[1:0] != 2'b11);
        w   = '0;
        case (f)
            3'd0: w = {f7, s2, s1, f3, d, op};
            3'd1: begin
                bad = bad || (s < -2048) || (s > 2047);
                w   = {im[11:0], s1, f3, d, op};
            end
            3'd2: begin
                bad = bad || (s < -2048) || (s > 2047);
                w   = {im[11:5], s2, s1, f3, im[4:0], op};
            end
            3'd3: begin
                bad = bad || (s < -4096) || (s > 4095) || (s % 2 != 0);
                w   = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            end
            3'd4: begin
                bad = bad || ((s % 4096) != 0);
                w   = {im[31:12], d, op};
            end
            3'd5: begin
                bad = bad || (s < -1048576) || (s > 1048575) || (s % 2 != 0);
                w   = {im[20], im[10:1], im[11], im[19:12], d, op};
            end
            default: bad = 1'b1;
        endcase
        return bad ? {1'b1, 32'h0} : {1'b0, w};
    endfunction

    logic [32:0] q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (q.size() > 0) && rsp_ready;
            do_push = req_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [32:0] head;
            head = (q.size() > 0) ? q[0] : 33'h0;
            check("cmp_count", 32'(count), 32'(q.size()));
            check("cmp_req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
            check("cmp_rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
            check("cmp_instr", instr, head[31:0]);
            check("cmp_err", 32'(err), 32'(head[32]));
        end
    end

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        set_req(f, op, d, s1, s2, f3, f7, im);
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            acc = req_ready;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
        #1 req_valid = 1'b0;
    endtask

    task automatic expect_head(input string name, input logic [31:0] w, input logic e);
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_instr"}, instr, w);
        check({name, "_err"}, 32'(err), 32'(e));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        set_req(3'd0, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #3;
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Directed literal encodings; each head is observed 1 ns after its accepting edge.
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_head("addi", 32'h0050_0093, 1'b0);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        expect_head("beq_m4", 32'hFE00_0EE3, 1'b0);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_head("lui", 32'h1234_52B7, 1'b0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        expect_head("jal8", 32'h0080_00EF, 1'b0);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF);
        expect_head("sub", 32'h4020_81B3, 1'b0);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        expect_head("i_2048", 32'h0, 1'b1);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        expect_head("b_odd", 32'h0, 1'b1);
        send(3'd1, 7'h10, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        expect_head("bad_op", 32'h0, 1'b1);

        // Boundary patterns checked against the model only.
        send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd7, 7'd0, -32'sd2048);
        send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd7, 7'd0, -32'sd2049);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2047);
        send(3'd3, 7'h63, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 32'd4094);
        send(3'd3, 7'h63, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 32'd4096);
        send(3'd3, 7'h63, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, -32'sd4096);
        send(3'd5, 7'h6F, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574);
        send(3'd5, 7'h6F, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576);
        send(3'd5, 7'h6F, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        send(3'd4, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000);
        send(3'd4, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001);
        send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        send(3'd7, 7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("drained", 32'(count), 32'd0);

        // Backpressure: A, B fill the queue, C is held until space opens.
        rsp_ready = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        check("bp_full_count", 32'(count), 32'd2);
        check("bp_full_ready", 32'(req_ready), 32'd0);
        set_req(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_held_count", 32'(count), 32'd2);
        check("bp_stable_instr", instr, 32'h0050_0093);
        rsp_ready = 1'b1;
        check("bp_head_a", instr, 32'h0050_0093);
        @(negedge clk);
        check("bp_head_b", instr, 32'h0010_0113);
        check("bp_count_after_a", 32'(count), 32'd1);
        @(negedge clk);
        check("bp_head_c", instr, 32'h0020_0193);
        check("bp_pushpop_count", 32'(count), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_empty", 32'(count), 32'd0);
        check("bp_empty_instr", instr, 32'h0);

        // Flush with a full queue and a live request.
        rsp_ready = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        check("fl_pre_count", 32'(count), 32'd2);
        set_req(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        req_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_count", 32'(count), 32'd0);
        check("fl_valid", 32'(rsp_valid), 32'd0);
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("fl_not_enq", 32'(count), 32'd0);

        // Asynchronous reset mid-occupancy, then recovery.
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        check("ar_pre_count", 32'(count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_valid", 32'(rsp_valid), 32'd0);
        check("ar_instr", instr, 32'h0);
        check("ar_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_head("ar_lui", 32'h1234_52B7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
